// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the core-side fetch/data handshakes and the RAM-side bus used by
// mem_port_arbiter.
//   fetch : i_req, i_addr -> i_ack, i_rdata
//   data  : d_read, d_write, d_addr, d_width, d_wdata -> d_ack, d_rdata, d_err
//   ram   : mem_addr, mem_we, mem_wdata -> mem_rdata
// Modports:
//   slave  - the arbiter (receives core requests, drives the RAM bus)
//   master - the environment (core plus RAM model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 12
);
   logic          i_req;
   logic [31:0]   i_addr;
   logic          i_ack;
   logic [31:0]   i_rdata;
   logic          d_read;
   logic          d_write;
   logic [31:0]   d_addr;
   logic [1:0]    d_width;
   logic [31:0]   d_wdata;
   logic          d_ack;
   logic [31:0]   d_rdata;
   logic          d_err;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  i_req, i_addr, d_read, d_write, d_addr, d_width, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, d_err, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_read, d_write, d_addr, d_width, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, d_err, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous-read RAM between the instruction fetch
// port and the data load/store port. Round-robin arbitration in IDLE, byte-lane
// alignment for loads, read-modify-write for byte/half stores, and an error
// response for out-of-range or misaligned data accesses.
// Ports:
//   clock - system clock, all logic on posedge
//   reset - synchronous, active-high; aborts any transaction in flight
//   bus   - mem_port_arbiter_if.slave (fetch, data and RAM signals)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MEM_WORDS = 4096,
   parameter int AW        = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_port_arbiter_if.slave     bus
);

   localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_RESP_I,
      S_LOAD,
      S_RESP_D,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_ERR
   } state_t;

   typedef enum logic {
      GNT_INSTR,
      GNT_DATA
   } grant_t;

   state_t        state_q, state_d;
   grant_t        last_grant_q, last_grant_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;   // store data, LSB-justified
   logic [1:0]    off_q, off_d;               // byte offset within the word
   logic [1:0]    width_q, width_d;

   logic          d_req;
   logic          grant_data;
   logic [2:0]    d_bytes;
   logic          range_err;
   logic [3:0]    lane_mask;
   logic [31:0]   wdata_shifted;
   logic [31:0]   rmw_data;

   assign d_req = bus.d_read | bus.d_write;

   // Data wins a tie unless it was granted last; last_grant resets to INSTR so
   // the first contended grant after reset goes to data.
   assign grant_data = d_req && (!bus.i_req || (last_grant_q == GNT_INSTR));

   // Width encoding 3 has no defined size; zero bytes flags it as an error.
   always_comb begin
      d_bytes = 3'd0;
      case (bus.d_width)
         2'd0:    d_bytes = 3'd1;
         2'd1:    d_bytes = 3'd2;
         2'd2:    d_bytes = 3'd4;
         default: d_bytes = 3'd0;
      endcase
   end

   assign range_err = (bus.d_addr >= BYTE_LIMIT)
                   || (({1'b0, bus.d_addr[1:0]} + d_bytes) > 3'd4)
                   || (d_bytes == 3'd0);

   // Next-state logic.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise always_comb would infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      off_d        = off_q;
      width_d      = width_q;

      case (state_q)
         S_IDLE: begin
            if (grant_data) begin
               last_grant_d = GNT_DATA;
               off_d        = bus.d_addr[1:0];
               width_d      = bus.d_width;
               if (range_err) begin
                  state_d = S_ERR;
               end else begin
                  mem_addr_d = bus.d_addr[AW+1:2];
                  if (bus.d_write) begin
                     mem_wdata_d = bus.d_wdata;
                     if (bus.d_width == 2'd2) begin
                        state_d  = S_WR;
                        mem_we_d = 1'b1;
                     end else begin
                        state_d = S_RMW_RD;
                     end
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end else if (bus.i_req) begin
               last_grant_d = GNT_INSTR;
               mem_addr_d   = bus.i_addr[AW+1:2];
               state_d      = S_FETCH;
            end
         end
         S_FETCH:  state_d = S_RESP_I;
         S_LOAD:   state_d = S_RESP_D;
         S_RMW_RD: begin
            state_d  = S_RMW_WR;
            mem_we_d = 1'b1;
         end
         default:  state_d = S_IDLE;   // all terminal states
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= GNT_INSTR;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         off_q        <= '0;
         width_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         off_q        <= off_d;
         width_q      <= width_d;
      end
   end

   // Read-modify-write merge. The old word only arrives in the RMW_WR cycle,
   // so the merged value is muxed onto mem_wdata combinationally there.
   assign lane_mask     = ((width_q == 2'd0) ? 4'b0001 : 4'b0011) << off_q;
   assign wdata_shifted = mem_wdata_q << {off_q, 3'b000};

   always_comb begin
      rmw_data = bus.mem_rdata;
      for (int b = 0; b < 4; b++) begin
         if (lane_mask[b]) rmw_data[b*8 +: 8] = wdata_shifted[b*8 +: 8];
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = (state_q == S_RMW_WR) ? rmw_data : mem_wdata_q;

   assign bus.i_ack   = (state_q == S_RESP_I);
   assign bus.i_rdata = (state_q == S_RESP_I) ? bus.mem_rdata : '0;
   assign bus.d_ack   = (state_q == S_RESP_D) || (state_q == S_WR)
                     || (state_q == S_RMW_WR) || (state_q == S_ERR);
   assign bus.d_err   = (state_q == S_ERR);
   assign bus.d_rdata = (state_q == S_RESP_D) ? (bus.mem_rdata >> {off_q, 3'b000}) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural synchronous-read RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MEM_WORDS = 4096;
   localparam int AW        = 12;

   logic clock;
   logic reset;

   mem_port_arbiter_if #(.AW(AW)) bus ();

   mem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model with a bench-side preload port
   logic [31:0]   ram [MEM_WORDS];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [31:0]   pl_data;
   int            we_count;

   always @(posedge clock) begin
      if (pl_en)           ram[pl_addr] <= pl_data;
      else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) we_count <= we_count + 1;
   end

   int checks;
   int errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clock);
      pl_en   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Advances at least one cycle, then until any ack or the limit.
   task automatic wait_ack(input int limit, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!(bus.i_ack || bus.d_ack) && lat < limit);
   endtask

   task automatic clear_reqs();
      bus.i_req   = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   int lat;
   int we_before;

   initial begin
      checks = 0;
      errors = 0;
      we_count = 0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      reset = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0;
      bus.d_addr = '0; bus.d_width = '0; bus.d_wdata = '0;

      // ---------------- reset state
      repeat (2) @(negedge clock);
      check("rst_i_ack",     bus.i_ack, 0);
      check("rst_d_ack",     bus.d_ack, 0);
      check("rst_d_err",     bus.d_err, 0);
      check("rst_mem_we",    bus.mem_we, 0);
      check("rst_mem_addr",  32'(bus.mem_addr), 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_i_rdata",   bus.i_rdata, 0);
      check("rst_d_rdata",   bus.d_rdata, 0);
      reset = 1'b0;

      preload(12'h004, 32'hDEADBEEF);
      preload(12'h040, 32'h11223344);
      preload(12'h080, 32'hAAAAAAAA);
      preload(12'h041, 32'h01020304);

      // ---------------- fetch only
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
      wait_ack(8, lat);
      check("fetch_lat",   lat, 2);
      check("fetch_i_ack", bus.i_ack, 1);
      check("fetch_data",  bus.i_rdata, 32'hDEADBEEF);
      check("fetch_d_ack", bus.d_ack, 0);
      clear_reqs();
      @(negedge clock);
      check("fetch_ack_pulse", bus.i_ack, 0);

      // ---------------- contention: data first after reset, then alternate
      do_reset();
      bus.i_req  = 1'b1; bus.i_addr = 32'h0000_0010;
      bus.d_read = 1'b1; bus.d_addr = 32'h0000_0100; bus.d_width = 2'd2;
      for (int k = 0; k < 4; k++) begin
         wait_ack(8, lat);
         check($sformatf("rr_lat%0d", k), lat, (k == 0) ? 2 : 3);
         check($sformatf("rr_dack%0d", k), bus.d_ack, (k % 2 == 0) ? 1 : 0);
         check($sformatf("rr_both%0d", k), bus.i_ack & bus.d_ack, 0);
         if (k % 2 == 0) check($sformatf("rr_ld%0d", k), bus.d_rdata, 32'h11223344);
         else            check($sformatf("rr_if%0d", k), bus.i_rdata, 32'hDEADBEEF);
      end
      clear_reqs();
      repeat (2) @(negedge clock);

      // ---------------- byte store via RMW
      bus.d_write = 1'b1; bus.d_addr = 32'h0000_0102; bus.d_width = 2'd0;
      bus.d_wdata = 32'h0000_00AB;
      wait_ack(8, lat);
      check("sb_lat",      lat, 2);
      check("sb_d_ack",    bus.d_ack, 1);
      check("sb_err",      bus.d_err, 0);
      check("sb_we",       bus.mem_we, 1);
      check("sb_addr",     32'(bus.mem_addr), 32'h40);
      check("sb_wdata",    bus.mem_wdata, 32'h11AB3344);
      clear_reqs();
      @(negedge clock);
      check("sb_we_off",   bus.mem_we, 0);
      check("sb_ram",      ram[12'h040], 32'h11AB3344);

      // ---------------- half store at offset 2
      bus.d_write = 1'b1; bus.d_addr = 32'h0000_0202; bus.d_width = 2'd1;
      bus.d_wdata = 32'h0000_BEEF;
      wait_ack(8, lat);
      check("sh_lat",      lat, 2);
      clear_reqs();
      @(negedge clock);
      check("sh_ram",      ram[12'h080], 32'hBEEFAAAA);

      // ---------------- back-to-back word stores (every 2 cycles)
      bus.d_write = 1'b1; bus.d_addr = 32'h0000_0300; bus.d_width = 2'd2;
      bus.d_wdata = 32'h12345678;
      wait_ack(8, lat);
      check("sw_lat",      lat, 1);
      check("sw_we",       bus.mem_we, 1);
      bus.d_wdata = 32'hCAFEF00D;
      @(negedge clock);
      check("sw_ram1",     ram[12'h0C0], 32'h12345678);
      wait_ack(8, lat);
      check("sw_b2b_lat",  lat + 1, 2);
      clear_reqs();
      @(negedge clock);
      check("sw_ram2",     ram[12'h0C0], 32'hCAFEF00D);

      // ---------------- half load at 0x101
      bus.d_read = 1'b1; bus.d_addr = 32'h0000_0101; bus.d_width = 2'd1;
      wait_ack(8, lat);
      check("lh_lat",      lat, 2);
      check("lh_data",     bus.d_rdata, 32'h0011AB33);
      check("lh_err",      bus.d_err, 0);
      clear_reqs();
      @(negedge clock);

      // ---------------- misaligned word load -> error
      we_before = we_count;
      bus.d_read = 1'b1; bus.d_addr = 32'h0000_0102; bus.d_width = 2'd2;
      wait_ack(8, lat);
      check("lw_mis_lat",  lat, 1);
      check("lw_mis_err",  bus.d_err, 1);
      clear_reqs();
      @(negedge clock);
      check("lw_mis_err_pulse", bus.d_err, 0);
      check("lw_mis_ram",  ram[12'h040], 32'h11AB3344);

      // ---------------- out-of-range store -> error, no write
      bus.d_write = 1'b1; bus.d_addr = 32'(MEM_WORDS * 4); bus.d_width = 2'd2;
      bus.d_wdata = 32'hFFFFFFFF;
      wait_ack(8, lat);
      check("oor_lat",     lat, 1);
      check("oor_err",     bus.d_err, 1);
      clear_reqs();
      repeat (2) @(negedge clock);
      check("oor_no_we",   we_count - we_before, 0);

      // ---------------- reset during RMW_RD
      we_before = we_count;
      bus.d_write = 1'b1; bus.d_addr = 32'h0000_0104; bus.d_width = 2'd0;
      bus.d_wdata = 32'h0000_0055;
      @(negedge clock);                     // now in RMW_RD
      check("rmw_rst_ack0", bus.d_ack, 0);
      reset = 1'b1;
      clear_reqs();
      @(negedge clock);
      check("rmw_rst_we",   bus.mem_we, 0);
      check("rmw_rst_ack1", bus.d_ack, 0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("rmw_rst_idle_ack", bus.d_ack | bus.i_ack, 0);
      end
      check("rmw_rst_no_we", we_count - we_before, 0);
      check("rmw_rst_ram",   ram[12'h041], 32'h01020304);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
